// File: rtl/multiplier_22_if.sv
// rtl/multiplier_22_if.sv - start/done handshake and operand/result bundle for multiplier_22
interface multiplier_22_if;
    logic        start_sig;
    logic [15:0] a;
    logic [7:0]  b;
    logic [21:0] p;
    logic        done_sig;
    logic        busy;

    modport master (output start_sig, a, b, input p, done_sig, busy);
    modport slave  (input start_sig, a, b, output p, done_sig, busy);
endinterface

// File: rtl/multiplier_22.sv
// rtl/multiplier_22.sv - sequential signed 16x8 shift-add multiplier with FRAC_SHIFT rescale (option MUL22_ROUND_EN)
module multiplier_22 #(
    parameter int FRAC_SHIFT = 2
) (
    input  logic           clock,
    input  logic           rst_n,
    multiplier_22_if.slave bus
);

    generate
        if (FRAC_SHIFT < 2 || FRAC_SHIFT > 8) begin : g_bad_frac_shift
            $error("multiplier_22: FRAC_SHIFT must be in 2..8");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, MUL, SCALE, SIGN, DONE} state_t;

    localparam logic [3:0]  SHIFT_CNT = 4'(FRAC_SHIFT);
    localparam logic [22:0] RND_BIAS  = 23'(1) << (FRAC_SHIFT - 1);

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [16:0] ma_q, ma_d;
    logic [7:0]  mb_q, mb_d;
    logic [22:0] acc_q, acc_d;
    logic [2:0]  k_q, k_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [21:0] p_q, p_d;

    // Next-state and datapath: operands captured in LOAD, magnitude product built in MUL,
    // rescaled in SCALE, sign restored in SIGN; dropping start_sig always returns to IDLE.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (bus.start_sig) state_d = LOAD;
            end
            LOAD: begin
                sign_d  = bus.a[15] ^ bus.b[7];
                // 17-bit magnitude so that -32768 maps to +32768
                ma_d    = bus.a[15] ? 17'(-{1'b1, bus.a}) : {1'b0, bus.a};
                mb_d    = bus.b[7] ? 8'(-bus.b) : bus.b;
                acc_d   = '0;
                k_d     = '0;
                p_d     = '0;
                state_d = MUL;
            end
            MUL: begin
                if (mb_q[k_q]) acc_d = acc_q + (23'(ma_q) << k_q);
                k_d = 3'(k_q + 3'd1);
                if (k_q == 3'd7) begin
                    cnt_d   = SHIFT_CNT;
                    state_d = SCALE;
                end
            end
            SCALE: begin
`ifdef MUL22_ROUND_EN
                // Half-LSB bias on the magnitude before the first shift rounds half away from zero
                if (cnt_q == SHIFT_CNT) acc_d = (acc_q + RND_BIAS) >> 1;
                else                    acc_d = acc_q >> 1;
`else
                acc_d = acc_q >> 1;
`endif
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = SIGN;
            end
            SIGN: begin
                // Negating a zero magnitude gives zero, so no sign special case is needed
                p_d     = sign_q ? 22'(-acc_q[21:0]) : acc_q[21:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !bus.start_sig) begin
            state_d = IDLE;
            p_d     = p_q;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign bus.p        = p_q;
    assign bus.done_sig = (state_q == DONE);
    assign bus.busy     = (state_q != IDLE) && (state_q != DONE);

endmodule
